// File: rtl/arb_mux_nx1_if.sv
// arb_mux_nx1_if: channel and output handshake bundle for arb_mux_nx1.
//   In_Data   N*WIDTH  channel i word at [i*WIDTH +: WIDTH]
//   In_Valid  N        channel i offers a word
//   In_Ready  N        channel i word accepted this cycle (at most one bit set)
//   Sel       SW       channel select (select-driven mode only)
//   Out_Data  WIDTH    registered output word
//   Out_Valid 1        Out_Data holds a valid word
//   Out_Ready 1        downstream accepts Out_Data this cycle
//   Out_Chan  SW       source channel of Out_Data
// slave = mux side, master = driver/consumer side.
interface arb_mux_nx1_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SW    = $clog2(N)
);
  logic [N*WIDTH-1:0] In_Data;
  logic [N-1:0]       In_Valid;
  logic [N-1:0]       In_Ready;
  logic [SW-1:0]      Sel;
  logic [WIDTH-1:0]   Out_Data;
  logic               Out_Valid;
  logic               Out_Ready;
  logic [SW-1:0]      Out_Chan;

  modport slave (
    input  In_Data, In_Valid, Sel, Out_Ready,
    output In_Ready, Out_Data, Out_Valid, Out_Chan
  );

  modport master (
    output In_Data, In_Valid, Sel, Out_Ready,
    input  In_Ready, Out_Data, Out_Valid, Out_Chan
  );
endinterface

// File: rtl/arb_mux_nx1.sv
// arb_mux_nx1: N-to-1 multiplexer with a single registered output stage.
// MODE=0 picks the channel given by Sel; MODE=1 round-robins over valid
// channels starting at an internal pointer that advances past each winner.
// Ports:
//   Clk      rising-edge clock
//   Reset_n  synchronous active-low reset
//   bus      arb_mux_nx1_if.slave (channel inputs, output register, handshakes)
module arb_mux_nx1 #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SW    = $clog2(N)
) (
  input  logic         Clk,
  input  logic         Reset_n,
  arb_mux_nx1_if.slave bus
);

  localparam logic [SW:0]   N_EXT = (SW+1)'(N);
  localparam logic [SW-1:0] LAST  = SW'(N-1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  logic             ld;
  logic             cand_ok;
  logic [SW-1:0]    cand;
  logic             xfer;
  logic [N-1:0]     in_ready;

  // Output register can take a new word when empty or being drained.
  assign ld = ~out_valid_q | bus.Out_Ready;

  // Candidate channel. In select mode an out-of-range Sel (non power-of-2 N)
  // never qualifies. In round-robin mode the search wraps from ptr.
  always_comb begin : pick
    logic [SW:0]   sum;
    logic [SW-1:0] idx;
    cand    = '0;
    cand_ok = 1'b0;
    sum     = '0;
    idx     = '0;
    if (MODE == 0) begin
      cand    = bus.Sel;
      cand_ok = ({1'b0, bus.Sel} < N_EXT);
    end else begin
      for (int k = 0; k < N; k++) begin
        sum = {1'b0, ptr_q} + (SW+1)'(k);
        if (sum >= N_EXT) sum = sum - N_EXT;
        idx = sum[SW-1:0];
        if (!cand_ok && bus.In_Valid[idx]) begin
          cand    = idx;
          cand_ok = 1'b1;
        end
      end
    end
  end

  // Grant is suppressed during reset so no word is taken in that cycle.
  always_comb begin : grant
    in_ready = '0;
    xfer     = 1'b0;
    if (Reset_n && ld && cand_ok && bus.In_Valid[cand]) begin
      xfer           = 1'b1;
      in_ready[cand] = 1'b1;
    end
  end

  always_comb begin : next_state
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    // When loading with nothing to take, the register empties but keeps its
    // last data/channel.
    if (ld) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = bus.In_Data[cand*WIDTH +: WIDTH];
      out_chan_d = cand;
      ptr_d      = (cand == LAST) ? '0 : cand + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.In_Ready  = in_ready;
  assign bus.Out_Data  = out_data_q;
  assign bus.Out_Chan  = out_chan_q;
  assign bus.Out_Valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_nx1.sv
// tb_arb_mux_nx1: bench for arb_mux_nx1 with three instances:
//   dut0 N=4 select mode, dut1 N=4 round-robin, dut3 N=3 select mode.
module tb_arb_mux_nx1;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arb_mux_nx1_if #(.WIDTH(16), .N(4)) b0 ();
  arb_mux_nx1_if #(.WIDTH(16), .N(4)) b1 ();
  arb_mux_nx1_if #(.WIDTH(16), .N(3)) b3 ();

  arb_mux_nx1 #(.WIDTH(16), .N(4), .MODE(0)) dut0 (.Clk(clk), .Reset_n(rst_n), .bus(b0.slave));
  arb_mux_nx1 #(.WIDTH(16), .N(4), .MODE(1)) dut1 (.Clk(clk), .Reset_n(rst_n), .bus(b1.slave));
  arb_mux_nx1 #(.WIDTH(16), .N(3), .MODE(0)) dut3 (.Clk(clk), .Reset_n(rst_n), .bus(b3.slave));

  typedef struct {
    logic [1:0]  chan;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_ptr    = 0;
  logic [15:0] held_data;
  logic [1:0]  held_chan;

  // Reference round-robin choice for 4 channels; -1 when nothing is valid.
  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b0.In_Valid = 4'b1111; b0.Sel = 2'd0; b0.Out_Ready = 1'b1;
    b1.In_Valid = 4'b1111; b1.Sel = 2'd0; b1.Out_Ready = 1'b1;
    b3.In_Valid = 3'b111;  b3.Sel = 2'd0; b3.Out_Ready = 1'b1;
    #1;
    n_checks++; if (b0.In_Ready !== 4'b0000) $display("FAIL reset_in_ready_dut0 got %b want 0000", b0.In_Ready); else n_pass++;
    n_checks++; if (b1.In_Ready !== 4'b0000) $display("FAIL reset_in_ready_dut1 got %b want 0000", b1.In_Ready); else n_pass++;
    n_checks++; if (b3.In_Ready !== 3'b000)  $display("FAIL reset_in_ready_dut3 got %b want 000", b3.In_Ready); else n_pass++;
    tick();
    tick();
    n_checks++; if (b1.Out_Valid !== 1'b0)   $display("FAIL reset_out_valid got %b want 0", b1.Out_Valid); else n_pass++;
    n_checks++; if (b1.Out_Data !== 16'h0)   $display("FAIL reset_out_data got %h want 0000", b1.Out_Data); else n_pass++;
    n_checks++; if (b1.Out_Chan !== 2'd0)    $display("FAIL reset_out_chan got %0d want 0", b1.Out_Chan); else n_pass++;
    n_checks++; if (b0.Out_Valid !== 1'b0)   $display("FAIL reset_out_valid_dut0 got %b want 0", b0.Out_Valid); else n_pass++;
    m_ptr = 0;
  endtask

  // First cycle after release: select channel 2 carrying BEEF.
  task automatic test_first_xfer();
    rst_n = 1'b1;
    b1.In_Valid = 4'b0000;
    b3.In_Valid = 3'b000;
    b0.In_Data[47:32] = 16'hBEEF;
    b0.Sel = 2'd2; b0.In_Valid = 4'b0100; b0.Out_Ready = 1'b1;
    #1;
    n_checks++; if (b0.In_Ready !== 4'b0100) $display("FAIL sel_in_ready got %b want 0100", b0.In_Ready); else n_pass++;
    sb.push_back('{chan: 2'd2, data: 16'hBEEF});
    tick();
    e = sb.pop_front();
    n_checks++; if (b0.Out_Valid !== 1'b1)   $display("FAIL sel_out_valid got %b want 1", b0.Out_Valid); else n_pass++;
    n_checks++; if (b0.Out_Data !== e.data)  $display("FAIL sel_out_data got %h want %h", b0.Out_Data, e.data); else n_pass++;
    n_checks++; if (b0.Out_Chan !== e.chan)  $display("FAIL sel_out_chan got %0d want %0d", b0.Out_Chan, e.chan); else n_pass++;
    b0.In_Valid = 4'b0000;
    b0.In_Data[47:32] = 16'hA002;
  endtask

  task automatic test_rr_wrap();
    logic [3:0] er;
    b1.In_Valid = 4'b1111; b1.Out_Ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      int c;
      c  = rr_pick(b1.In_Valid, m_ptr);
      er = 4'b0001 << c;
      #1;
      n_checks++; if (b1.In_Ready !== er) $display("FAIL rr_in_ready[%0d] got %b want %b", n, b1.In_Ready, er); else n_pass++;
      sb.push_back('{chan: 2'(c), data: 16'h0010 + 16'(c)});
      tick();
      e = sb.pop_front();
      n_checks++; if (b1.Out_Valid !== 1'b1)  $display("FAIL rr_out_valid[%0d] got %b want 1", n, b1.Out_Valid); else n_pass++;
      n_checks++; if (b1.Out_Chan !== e.chan) $display("FAIL rr_out_chan[%0d] got %0d want %0d", n, b1.Out_Chan, e.chan); else n_pass++;
      n_checks++; if (b1.Out_Data !== e.data) $display("FAIL rr_out_data[%0d] got %h want %h", n, b1.Out_Data, e.data); else n_pass++;
      m_ptr = (c + 1) % 4;
    end
  endtask

  task automatic test_stall();
    logic [3:0] er;
    int c;
    c  = rr_pick(4'b1111, m_ptr);
    er = 4'b0001 << c;
    #1;
    n_checks++; if (b1.In_Ready !== er) $display("FAIL stall_first_in_ready got %b want %b", b1.In_Ready, er); else n_pass++;
    sb.push_back('{chan: 2'(c), data: 16'h0010 + 16'(c)});
    tick();
    e = sb.pop_front();
    n_checks++; if (b1.Out_Data !== e.data) $display("FAIL stall_first_data got %h want %h", b1.Out_Data, e.data); else n_pass++;
    m_ptr = (c + 1) % 4;
    held_data = e.data; held_chan = e.chan;
    b1.Out_Ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      n_checks++; if (b1.In_Ready !== 4'b0000) $display("FAIL stall_in_ready[%0d] got %b want 0000", n, b1.In_Ready); else n_pass++;
      tick();
      n_checks++; if (b1.Out_Valid !== 1'b1)     $display("FAIL stall_valid[%0d] got %b want 1", n, b1.Out_Valid); else n_pass++;
      n_checks++; if (b1.Out_Data !== held_data) $display("FAIL stall_data[%0d] got %h want %h", n, b1.Out_Data, held_data); else n_pass++;
      n_checks++; if (b1.Out_Chan !== held_chan) $display("FAIL stall_chan[%0d] got %0d want %0d", n, b1.Out_Chan, held_chan); else n_pass++;
    end
    b1.Out_Ready = 1'b1;
    c  = rr_pick(4'b1111, m_ptr);
    er = 4'b0001 << c;
    #1;
    n_checks++; if (b1.In_Ready !== er) $display("FAIL release_in_ready got %b want %b", b1.In_Ready, er); else n_pass++;
    sb.push_back('{chan: 2'(c), data: 16'h0010 + 16'(c)});
    tick();
    e = sb.pop_front();
    n_checks++; if (b1.Out_Chan !== e.chan) $display("FAIL release_chan got %0d want %0d", b1.Out_Chan, e.chan); else n_pass++;
    n_checks++; if (b1.Out_Data !== e.data) $display("FAIL release_data got %h want %h", b1.Out_Data, e.data); else n_pass++;
    m_ptr = (c + 1) % 4;
    held_data = e.data; held_chan = e.chan;
  endtask

  // Sparse valid patterns: skip-ahead, wrap, and an idle cycle.
  task automatic test_rr_skip();
    logic [3:0] pats [6];
    logic [3:0] er;
    pats = '{4'b0001, 4'b1001, 4'b1001, 4'b0000, 4'b0110, 4'b0100};
    b1.Out_Ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      int c;
      b1.In_Valid = pats[n];
      c  = rr_pick(pats[n], m_ptr);
      er = (c < 0) ? 4'b0000 : (4'b0001 << c);
      #1;
      n_checks++; if (b1.In_Ready !== er) $display("FAIL skip_in_ready[%0d] got %b want %b", n, b1.In_Ready, er); else n_pass++;
      if (c >= 0) sb.push_back('{chan: 2'(c), data: 16'h0010 + 16'(c)});
      tick();
      if (c >= 0) begin
        e = sb.pop_front();
        n_checks++; if (b1.Out_Valid !== 1'b1)  $display("FAIL skip_valid[%0d] got %b want 1", n, b1.Out_Valid); else n_pass++;
        n_checks++; if (b1.Out_Chan !== e.chan) $display("FAIL skip_chan[%0d] got %0d want %0d", n, b1.Out_Chan, e.chan); else n_pass++;
        n_checks++; if (b1.Out_Data !== e.data) $display("FAIL skip_data[%0d] got %h want %h", n, b1.Out_Data, e.data); else n_pass++;
        m_ptr = (c + 1) % 4;
        held_data = e.data; held_chan = e.chan;
      end else begin
        n_checks++; if (b1.Out_Valid !== 1'b0)     $display("FAIL idle_valid[%0d] got %b want 0", n, b1.Out_Valid); else n_pass++;
        n_checks++; if (b1.Out_Data !== held_data) $display("FAIL idle_data_hold[%0d] got %h want %h", n, b1.Out_Data, held_data); else n_pass++;
        n_checks++; if (b1.Out_Chan !== held_chan) $display("FAIL idle_chan_hold[%0d] got %0d want %0d", n, b1.Out_Chan, held_chan); else n_pass++;
      end
    end
  endtask

  // Sel changes while stalled must not matter until the register can load.
  task automatic test_sel_stall();
    b0.In_Valid = 4'b1111; b0.Sel = 2'd1; b0.Out_Ready = 1'b0;
    #1;
    n_checks++; if (b0.In_Ready !== 4'b0010) $display("FAIL selst_in_ready got %b want 0010", b0.In_Ready); else n_pass++;
    sb.push_back('{chan: 2'd1, data: 16'hA001});
    tick();
    e = sb.pop_front();
    n_checks++; if (b0.Out_Data !== e.data) $display("FAIL selst_data got %h want %h", b0.Out_Data, e.data); else n_pass++;
    b0.Sel = 2'd3;
    #1;
    n_checks++; if (b0.In_Ready !== 4'b0000) $display("FAIL selst_stall_ready got %b want 0000", b0.In_Ready); else n_pass++;
    tick();
    n_checks++; if (b0.Out_Chan !== e.chan) $display("FAIL selst_stall_chan got %0d want %0d", b0.Out_Chan, e.chan); else n_pass++;
    n_checks++; if (b0.Out_Data !== e.data) $display("FAIL selst_stall_data got %h want %h", b0.Out_Data, e.data); else n_pass++;
    b0.Sel = 2'd2; b0.Out_Ready = 1'b1;
    #1;
    n_checks++; if (b0.In_Ready !== 4'b0100) $display("FAIL selst_release_ready got %b want 0100", b0.In_Ready); else n_pass++;
    sb.push_back('{chan: 2'd2, data: 16'hA002});
    tick();
    e = sb.pop_front();
    n_checks++; if (b0.Out_Chan !== e.chan) $display("FAIL selst_release_chan got %0d want %0d", b0.Out_Chan, e.chan); else n_pass++;
    n_checks++; if (b0.Out_Data !== e.data) $display("FAIL selst_release_data got %h want %h", b0.Out_Data, e.data); else n_pass++;
    b0.In_Valid = 4'b0000;
  endtask

  // N=3: Sel=3 is out of range and must never grant.
  task automatic test_n3();
    b3.In_Valid = 3'b111; b3.Sel = 2'd1; b3.Out_Ready = 1'b1;
    #1;
    n_checks++; if (b3.In_Ready !== 3'b010) $display("FAIL n3_in_ready got %b want 010", b3.In_Ready); else n_pass++;
    sb.push_back('{chan: 2'd1, data: 16'hC001});
    tick();
    e = sb.pop_front();
    n_checks++; if (b3.Out_Data !== e.data) $display("FAIL n3_data got %h want %h", b3.Out_Data, e.data); else n_pass++;
    b3.Sel = 2'd3;
    for (int n = 0; n < 2; n++) begin
      #1;
      n_checks++; if (b3.In_Ready !== 3'b000) $display("FAIL n3_oob_ready[%0d] got %b want 000", n, b3.In_Ready); else n_pass++;
      tick();
      n_checks++; if (b3.Out_Valid !== 1'b0)  $display("FAIL n3_oob_valid[%0d] got %b want 0", n, b3.Out_Valid); else n_pass++;
      n_checks++; if (b3.Out_Data !== e.data) $display("FAIL n3_oob_data[%0d] got %h want %h", n, b3.Out_Data, e.data); else n_pass++;
    end
    b3.In_Valid = 3'b000;
  endtask

  task automatic test_reset_mid();
    logic [3:0] er;
    int c;
    b1.In_Valid = 4'b0110; b1.Out_Ready = 1'b1;
    c = rr_pick(4'b0110, m_ptr);
    #1;
    sb.push_back('{chan: 2'(c), data: 16'h0010 + 16'(c)});
    tick();
    e = sb.pop_front();
    n_checks++; if (b1.Out_Chan !== e.chan) $display("FAIL rmid_load_chan got %0d want %0d", b1.Out_Chan, e.chan); else n_pass++;
    m_ptr = (c + 1) % 4;
    b1.In_Valid = 4'b1111; b1.Out_Ready = 1'b0;
    b0.In_Valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    n_checks++; if (b1.In_Ready !== 4'b0000) $display("FAIL rmid_in_ready got %b want 0000", b1.In_Ready); else n_pass++;
    n_checks++; if (b0.In_Ready !== 4'b0000) $display("FAIL rmid_in_ready_dut0 got %b want 0000", b0.In_Ready); else n_pass++;
    tick();
    n_checks++; if (b1.Out_Valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", b1.Out_Valid); else n_pass++;
    n_checks++; if (b1.Out_Data !== 16'h0) $display("FAIL rmid_data got %h want 0000", b1.Out_Data); else n_pass++;
    n_checks++; if (b1.Out_Chan !== 2'd0)  $display("FAIL rmid_chan got %0d want 0", b1.Out_Chan); else n_pass++;
    b1.Out_Ready = 1'b1;
    #1;
    n_checks++; if (b1.In_Ready !== 4'b0000) $display("FAIL rmid_in_ready2 got %b want 0000", b1.In_Ready); else n_pass++;
    tick();
    m_ptr = 0;
    rst_n = 1'b1;
    b0.In_Valid = 4'b0000;
    b1.In_Valid = 4'b0000; b1.Out_Ready = 1'b0;
    tick();
    n_checks++; if (b1.Out_Valid !== 1'b0) $display("FAIL rmid_after_release_valid got %b want 0", b1.Out_Valid); else n_pass++;
    b1.In_Valid = 4'b1111; b1.Out_Ready = 1'b1;
    c  = rr_pick(4'b1111, m_ptr);
    er = 4'b0001 << c;
    #1;
    n_checks++; if (b1.In_Ready !== er) $display("FAIL rmid_ptr_reset_ready got %b want %b", b1.In_Ready, er); else n_pass++;
    sb.push_back('{chan: 2'(c), data: 16'h0010 + 16'(c)});
    tick();
    e = sb.pop_front();
    n_checks++; if (b1.Out_Chan !== e.chan) $display("FAIL rmid_ptr_reset_chan got %0d want %0d", b1.Out_Chan, e.chan); else n_pass++;
    n_checks++; if (b1.Out_Data !== e.data) $display("FAIL rmid_ptr_reset_data got %h want %h", b1.Out_Data, e.data); else n_pass++;
  endtask

  initial begin
    b0.In_Data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    b1.In_Data = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    b3.In_Data = {16'hC002, 16'hC001, 16'hC000};
    test_reset();
    test_first_xfer();
    test_rr_wrap();
    test_stall();
    test_rr_skip();
    test_sel_stall();
    test_n3();
    test_reset_mid();
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
